// File: rtl/mem_if_pkg.sv
// Shared definitions for the memory interface controller: FSM states,
// access-size encodings and the default number of memory wait states.
package mem_if_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_WIDE = 2'b11;   // decoded as a word

   localparam int WAIT_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/lane_aligner.sv
// Big-endian byte-lane logic: store steering, byte enables, load
// extraction with sign/zero extension, and the alignment check.
module lane_aligner
   import mem_if_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic        se,
   input  logic [31:0] wdata,
   input  logic [31:0] mem_rdata,
   output logic [3:0]  be,
   output logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic        misaligned
);

   // Lane 0 is the most significant byte of the memory word.
   logic [7:0] lane [4];
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lane[gi] = mem_rdata[31 - 8*gi -: 8];
      end
   endgenerate

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      be         = 4'b0000;
      store_data = '0;
      load_data  = '0;
      misaligned = 1'b0;
      byte_sel   = lane[addr_lo];
      half_sel   = addr_lo[1] ? mem_rdata[15:0] : mem_rdata[31:16];

      case (size)
         SIZE_BYTE: begin
            be         = 4'b1000 >> addr_lo;
            store_data = {4{wdata[7:0]}};
            load_data  = {{24{se & byte_sel[7]}}, byte_sel};
         end
         SIZE_HALF: begin
            be         = addr_lo[1] ? 4'b0011 : 4'b1100;
            store_data = {2{wdata[15:0]}};
            load_data  = {{16{se & half_sel[15]}}, half_sel};
            misaligned = addr_lo[0];
         end
         default: begin
            be         = 4'b1111;
            store_data = wdata;
            load_data  = mem_rdata;
            misaligned = |addr_lo;
         end
      endcase
   end

endmodule

// File: rtl/memory_interface_controller.sv
// Four-phase MOV/MOC memory interface: latches a request, performs one
// strobed access with WAIT_CYCLES wait states, and returns aligned load data.
module memory_interface_controller
   import mem_if_pkg::*;
#(
   parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        MOV,
   input  logic        RW,
   input  logic [1:0]  SIZE,
   input  logic        SE,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        MOC,
   output logic        AE,
   output logic        busy,
   output logic        mem_en,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

   state_t      state_reg, state_next;
   logic        rw_reg;
   logic [1:0]  size_reg;
   logic        se_reg;
   logic [31:0] addr_reg;
   logic [31:0] wdata_reg;
   logic [3:0]  cnt_reg, cnt_next;
   logic        ae_reg, ae_next;
   logic [31:0] rdata_reg, rdata_next;
   logic        accept;

   logic [1:0]  al_size;
   logic [1:0]  al_addr_lo;
   logic [3:0]  al_be;
   logic [31:0] al_store;
   logic [31:0] al_load;
   logic        al_misaligned;

   // In IDLE the aligner checks the live request; afterwards it works on the latched one.
   assign al_size    = (state_reg == ST_IDLE) ? SIZE       : size_reg;
   assign al_addr_lo = (state_reg == ST_IDLE) ? addr[1:0]  : addr_reg[1:0];

   lane_aligner u_lane_aligner (
      .size       (al_size),
      .addr_lo    (al_addr_lo),
      .se         (se_reg),
      .wdata      (wdata_reg),
      .mem_rdata  (mem_rdata),
      .be         (al_be),
      .store_data (al_store),
      .load_data  (al_load),
      .misaligned (al_misaligned)
   );

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      ae_next    = ae_reg;
      rdata_next = rdata_reg;
      accept     = 1'b0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_be     = 4'b0000;
      MOC        = 1'b0;
      busy       = (state_reg != ST_IDLE);

      case (state_reg)
         ST_IDLE: begin
            if (MOV) begin
               accept     = 1'b1;
               ae_next    = al_misaligned;
               state_next = al_misaligned ? ST_DONE : ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            mem_en     = 1'b1;
            mem_we     = ~rw_reg;
            mem_be     = al_be;
            cnt_next   = WAIT_LOAD;
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_next = cnt_reg - 4'd1;
            if (cnt_reg == 4'd1) begin
               state_next = ST_DONE;
               if (rw_reg) begin
                  rdata_next = al_load;
               end
            end
         end
         ST_DONE: begin
            MOC = 1'b1;
            if (!MOV) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_IDLE;
         rw_reg    <= 1'b0;
         size_reg  <= SIZE_BYTE;
         se_reg    <= 1'b0;
         addr_reg  <= '0;
         wdata_reg <= '0;
         cnt_reg   <= '0;
         ae_reg    <= 1'b0;
         rdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         ae_reg    <= ae_next;
         rdata_reg <= rdata_next;
         if (accept) begin
            rw_reg    <= RW;
            size_reg  <= SIZE;
            se_reg    <= SE;
            addr_reg  <= addr;
            wdata_reg <= wdata;
         end
      end
   end

   assign rdata     = rdata_reg;
   assign AE        = ae_reg;
   assign mem_addr  = addr_reg[31:2];
   assign mem_wdata = al_store;

endmodule

// File: tb/tb_memory_interface_controller.sv
// Directed self-checking bench for memory_interface_controller with a
// one-word memory model that answers the cycle after each strobe.
module tb_memory_interface_controller;
   import mem_if_pkg::*;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        MOV = 1'b0;
   logic        RW = 1'b0;
   logic [1:0]  SIZE = 2'b00;
   logic        SE = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] mem_rdata = '0;
   logic [31:0] mem_word = '0;
   logic [31:0] rdata;
   logic        MOC, AE, busy, mem_en, mem_we;
   logic [3:0]  mem_be;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          en_total = 0;
   int          we_total = 0;
   logic [3:0]  cap_be = '0;
   logic [29:0] cap_addr = '0;
   logic [31:0] cap_wdata = '0;

   memory_interface_controller #(.WAIT_CYCLES(W)) dut (
      .clk(clk), .reset(reset), .MOV(MOV), .RW(RW), .SIZE(SIZE), .SE(SE),
      .addr(addr), .wdata(wdata), .rdata(rdata), .MOC(MOC), .AE(AE), .busy(busy),
      .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory model and strobe monitor: values seen in the cycle before each edge.
   always @(posedge clk) begin
      if (mem_en === 1'b1) begin
         en_total++;
         cap_be    = mem_be;
         cap_addr  = mem_addr;
         cap_wdata = mem_wdata;
         mem_rdata <= mem_word;
      end
      if (mem_we === 1'b1) we_total++;
   end

   // lat counts edges from the accepting edge (inclusive) to the first MOC sample.
   task automatic run_req(input logic rw, input logic [1:0] sz, input logic se,
                          input logic [31:0] a, input logic [31:0] wd, output int lat);
      RW = rw; SIZE = sz; SE = se; addr = a; wdata = wd; MOV = 1'b1;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (MOC !== 1'b1 && lat < 40);
   endtask

   task automatic release_mov;
      MOV = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({MOC, AE, busy, mem_en, mem_we, mem_be, mem_addr, mem_wdata, rdata} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got MOC=%b AE=%b busy=%b en=%b we=%b be=%b addr=%h wd=%h rd=%h want all zero",
                  MOC, AE, busy, mem_en, mem_we, mem_be, mem_addr, mem_wdata, rdata);
      end
      reset = 1'b1;
   endtask

   task automatic test_word_read;
      int lat, e0, w0;
      mem_word = 32'hDEADBEEF; e0 = en_total; w0 = we_total;
      run_req(1'b1, SIZE_WORD, 1'b0, 32'h0000_0010, 32'h0, lat);
      n_cmp++; if (lat !== W + 2) begin n_bad++; $display("FAIL word_latency: got %0d want %0d", lat, W + 2); end
      n_cmp++; if (en_total - e0 !== 1) begin n_bad++; $display("FAIL word_en_count: got %0d want 1", en_total - e0); end
      n_cmp++; if (we_total - w0 !== 0) begin n_bad++; $display("FAIL word_we_count: got %0d want 0", we_total - w0); end
      n_cmp++; if (cap_addr !== 30'h4) begin n_bad++; $display("FAIL word_mem_addr: got %h want 4", cap_addr); end
      n_cmp++; if (rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL word_rdata: got %h want deadbeef", rdata); end
      release_mov;
      n_cmp++; if ({MOC, busy} !== 2'b00) begin n_bad++; $display("FAIL word_return_idle: got MOC=%b busy=%b want 0 0", MOC, busy); end
      $display("word read addr=00000010 lat=%0d rdata=%h", lat, rdata);
   endtask

   task automatic test_loads;
      logic [1:0]  sz [6];
      logic        se [6];
      logic [31:0] ad [6];
      logic [31:0] wd [6];
      logic [31:0] ex [6];
      int lat;
      sz = '{SIZE_BYTE, SIZE_BYTE, SIZE_HALF, SIZE_HALF, SIZE_BYTE, SIZE_WIDE};
      se = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      ad = '{32'h13, 32'h13, 32'h02, 32'h00, 32'h11, 32'h08};
      wd = '{32'h123456F0, 32'h123456F0, 32'h80017FFE, 32'h80017FFE, 32'h12A456F0, 32'hCAFEF00D};
      ex = '{32'hFFFFFFF0, 32'h000000F0, 32'h00007FFE, 32'hFFFF8001, 32'hFFFFFFA4, 32'hCAFEF00D};
      for (int i = 0; i < 6; i++) begin
         mem_word = wd[i];
         run_req(1'b1, sz[i], se[i], ad[i], 32'h0, lat);
         n_cmp++; if (rdata !== ex[i]) begin n_bad++; $display("FAIL load_rdata[%0d]: got %h want %h", i, rdata, ex[i]); end
         n_cmp++; if (lat !== W + 2) begin n_bad++; $display("FAIL load_latency[%0d]: got %0d want %0d", i, lat, W + 2); end
         release_mov;
         $display("load size=%b se=%b addr=%h word=%h rdata=%h", sz[i], se[i], ad[i], wd[i], rdata);
      end
   endtask

   task automatic test_writes;
      logic [1:0]  sz [4];
      logic [31:0] ad [4];
      logic [31:0] wd [4];
      logic [3:0]  eb [4];
      logic [31:0] ew [4];
      int lat, w0;
      sz = '{SIZE_HALF, SIZE_BYTE, SIZE_WORD, SIZE_HALF};
      ad = '{32'h22, 32'h41, 32'h80, 32'h20};
      wd = '{32'h0000ABCD, 32'h0000005A, 32'h01234567, 32'h00001234};
      eb = '{4'b0011, 4'b0100, 4'b1111, 4'b1100};
      ew = '{32'hABCDABCD, 32'h5A5A5A5A, 32'h01234567, 32'h12341234};
      for (int i = 0; i < 4; i++) begin
         w0 = we_total;
         run_req(1'b0, sz[i], 1'b0, ad[i], wd[i], lat);
         n_cmp++; if (cap_be !== eb[i]) begin n_bad++; $display("FAIL write_be[%0d]: got %b want %b", i, cap_be, eb[i]); end
         n_cmp++; if (cap_wdata !== ew[i]) begin n_bad++; $display("FAIL write_wdata[%0d]: got %h want %h", i, cap_wdata, ew[i]); end
         n_cmp++; if (cap_addr !== ad[i][31:2]) begin n_bad++; $display("FAIL write_addr[%0d]: got %h want %h", i, cap_addr, ad[i][31:2]); end
         n_cmp++; if (we_total - w0 !== 1) begin n_bad++; $display("FAIL write_we_count[%0d]: got %0d want 1", i, we_total - w0); end
         n_cmp++; if (rdata !== 32'hCAFEF00D) begin n_bad++; $display("FAIL write_rdata_kept[%0d]: got %h want cafef00d", i, rdata); end
         release_mov;
         $display("write size=%b addr=%h wdata=%h be=%b mem_wdata=%h", sz[i], ad[i], wd[i], cap_be, cap_wdata);
      end
   endtask

   task automatic test_misaligned;
      logic [1:0]  sz [3];
      logic [31:0] ad [3];
      int lat, e0;
      sz = '{SIZE_WORD, SIZE_HALF, SIZE_WORD};
      ad = '{32'h06, 32'h03, 32'h01};
      for (int i = 0; i < 3; i++) begin
         e0 = en_total;
         run_req(1'b1, sz[i], 1'b0, ad[i], 32'h0, lat);
         n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL misalign_latency[%0d]: got %0d want 1", i, lat); end
         n_cmp++; if (AE !== 1'b1) begin n_bad++; $display("FAIL misalign_ae[%0d]: got %b want 1", i, AE); end
         n_cmp++; if (en_total - e0 !== 0) begin n_bad++; $display("FAIL misalign_no_strobe[%0d]: got %0d want 0", i, en_total - e0); end
         n_cmp++; if (rdata !== 32'hCAFEF00D) begin n_bad++; $display("FAIL misalign_rdata_kept[%0d]: got %h want cafef00d", i, rdata); end
         release_mov;
         $display("misaligned size=%b addr=%h AE=%b lat=%0d", sz[i], ad[i], AE, lat);
      end
   endtask

   task automatic test_hold_mov;
      int lat, e0;
      mem_word = 32'h0BADF00D; e0 = en_total;
      run_req(1'b1, SIZE_WORD, 1'b0, 32'h0000_0100, 32'h0, lat);
      n_cmp++; if (AE !== 1'b0) begin n_bad++; $display("FAIL ae_cleared: got %b want 0", AE); end
      n_cmp++; if (rdata !== 32'h0BADF00D) begin n_bad++; $display("FAIL hold_rdata: got %h want 0badf00d", rdata); end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_cmp++; if (MOC !== 1'b1) begin n_bad++; $display("FAIL hold_moc[%0d]: got %b want 1", i, MOC); end
      end
      n_cmp++; if (en_total - e0 !== 1) begin n_bad++; $display("FAIL hold_single_access: got %0d want 1", en_total - e0); end
      release_mov;
      n_cmp++; if ({MOC, busy} !== 2'b00) begin n_bad++; $display("FAIL hold_return_idle: got MOC=%b busy=%b want 0 0", MOC, busy); end
      $display("hold MOV: lat=%0d accesses=%0d", lat, en_total - e0);
   endtask

   task automatic test_mov_drop_early;
      int lat, e0;
      mem_word = 32'h7F000000; e0 = en_total;
      RW = 1'b1; SIZE = SIZE_BYTE; SE = 1'b1; addr = 32'h0; MOV = 1'b1;
      @(posedge clk); #1;
      MOV = 1'b0;
      lat = 1;
      while (MOC !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      n_cmp++; if (lat !== W + 2) begin n_bad++; $display("FAIL early_drop_latency: got %0d want %0d", lat, W + 2); end
      n_cmp++; if (rdata !== 32'h0000007F) begin n_bad++; $display("FAIL early_drop_rdata: got %h want 0000007f", rdata); end
      @(posedge clk); #1;
      n_cmp++; if ({MOC, busy} !== 2'b00) begin n_bad++; $display("FAIL early_drop_one_cycle: got MOC=%b busy=%b want 0 0", MOC, busy); end
      n_cmp++; if (en_total - e0 !== 1) begin n_bad++; $display("FAIL early_drop_accesses: got %0d want 1", en_total - e0); end
      $display("MOV dropped in ACCESS: lat=%0d rdata=%h", lat, rdata);
   endtask

   task automatic test_reset_mid;
      int lat, w0;
      RW = 1'b0; SIZE = SIZE_WORD; SE = 1'b0; addr = 32'h40; wdata = 32'h55AA55AA; MOV = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midreset_busy_before: got %b want 1", busy); end
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({MOC, AE, busy, mem_en, mem_we, mem_be, mem_addr, mem_wdata, rdata} !== '0) begin
         n_bad++;
         $display("FAIL midreset_outputs: got MOC=%b AE=%b busy=%b en=%b we=%b be=%b addr=%h wd=%h rd=%h want all zero",
                  MOC, AE, busy, mem_en, mem_we, mem_be, mem_addr, mem_wdata, rdata);
      end
      MOV = 1'b0;
      w0 = we_total;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (we_total - w0 !== 0) begin n_bad++; $display("FAIL midreset_no_write: got %0d want 0", we_total - w0); end
      reset = 1'b1;
      mem_word = 32'h13579BDF;
      run_req(1'b1, SIZE_WORD, 1'b0, 32'h0000_0010, 32'h0, lat);
      n_cmp++; if (lat !== W + 2) begin n_bad++; $display("FAIL postreset_latency: got %0d want %0d", lat, W + 2); end
      n_cmp++; if (rdata !== 32'h13579BDF) begin n_bad++; $display("FAIL postreset_rdata: got %h want 13579bdf", rdata); end
      release_mov;
      $display("reset in WAIT then read: lat=%0d rdata=%h", lat, rdata);
   endtask

   initial begin
      test_reset;
      test_word_read;
      test_loads;
      test_writes;
      test_misaligned;
      test_hold_mov;
      test_mov_drop_early;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/memory_interface_controller.md
MEMORY_INTERFACE_CONTROLLER -- requirements
Module: memory_interface_controller

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, memory wait states per access; legal range 1..15.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 MOV  in  1  memory operation valid, from the control unit; held high until MOC is seen.
REQ-005 RW  in  1  1 = read, 0 = write; sampled with MOV.
REQ-006 SIZE  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-007 SE  in  1  sign-extend sub-word read data when 1, zero-extend when 0.
REQ-008 addr  in  32  byte address from MAR.
REQ-009 wdata  in  32  store data from MDR.
REQ-010 rdata  out  32  registered, aligned load data to MDR.
REQ-011 MOC  out  1  memory operation complete, to the control unit.
REQ-012 AE  out  1  alignment error flag for the current/last request.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 mem_en, mem_we  out  1 each  memory strobe and write enable.
REQ-015 mem_be  out  4  byte enables; bit 3 = bits 31:24.
REQ-016 mem_addr  out  30  word address (addr[31:2] latched).
REQ-017 mem_wdata  out  32  lane-steered store data.
REQ-018 mem_rdata  in  32  memory read data, valid the cycle after mem_en and held until the next mem_en.

Function
REQ-019 The FSM SHALL have the states IDLE, ACCESS, WAIT and DONE.
REQ-020 In IDLE with MOV=1, the block SHALL latch RW, SIZE, SE, addr and wdata, then take one of two paths.
  - Aligned request: go to ACCESS.
  - Misaligned request (halfword with addr[0]=1, or word with addr[1:0]!=0): go to DONE with AE=1 and issue no memory strobe.
REQ-021 ACCESS SHALL last one cycle with mem_en=1, mem_we=~RW, and mem_be/mem_wdata/mem_addr valid; it SHALL load the wait counter with WAIT_CYCLES.
REQ-022 WAIT SHALL decrement the counter each cycle and go to DONE when the counter reaches 1; on that edge, reads SHALL capture the aligned mem_rdata into rdata.
REQ-023 mem_en and mem_we SHALL be 0 in every state other than ACCESS.
REQ-024 Latency: MOC SHALL first be high WAIT_CYCLES+2 edges after the edge that sampled MOV=1 in IDLE (4 edges for the default).
REQ-025 DONE SHALL drive MOC=1 and hold it while MOV=1; when MOV=0, the next edge SHALL return to IDLE with MOC=0 (four-phase handshake, so one request can never cause a double access).
REQ-026 If MOV falls during ACCESS or WAIT, the access SHALL still complete, and MOC SHALL be high for exactly one cycle in DONE.
REQ-027 Big-endian byte-lane rules:
  - Byte: lane = addr[1:0] (0 maps to bits 31:24); be is one-hot (00 gives 1000); mem_wdata = wdata[7:0] replicated to all four lanes.
  - Halfword: addr[1]=0 gives be 1100, addr[1]=1 gives be 0011; mem_wdata = {wdata[15:0], wdata[15:0]}.
  - Word: be 1111; mem_wdata = wdata.
REQ-028 Load extraction SHALL select the addressed lane(s) and extend to 32 bits per SE; a word load SHALL pass through unchanged.
REQ-029 rdata SHALL change only on a completed aligned read; writes and misaligned requests SHALL leave rdata unchanged.
REQ-030 AE SHALL clear on the next request that is accepted in IDLE.

Reset
REQ-031 While reset=0, the block SHALL asynchronously force IDLE, MOC=0, AE=0, busy=0, mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, rdata=0 and counter=0.
REQ-032 Reset asserted mid-access SHALL abort the access; no write strobe SHALL appear after reset asserts.
REQ-033 After reset deasserts, the first MOV=1 SHALL be accepted on the next edge.

Structure
REQ-034 The shared package mem_if_pkg SHALL hold the state encoding, the SIZE encodings and the WAIT_CYCLES default.
REQ-035 One combinational sub-module, lane_aligner, SHALL implement store steering, byte enables, load extraction/extension and the misalignment check; the FSM and registers SHALL stay in the top module.

Verification
REQ-036 Word read, addr=0x00000010, memory word 0xDEADBEEF, WAIT=2 -> mem_en for one cycle with mem_addr=0x4; MOC high 4 edges after acceptance; rdata=0xDEADBEEF.
REQ-037 Byte read with SE=1, addr=0x...13, word 0x123456F0 -> rdata=0xFFFFFFF0; the same read with SE=0 -> rdata=0x000000F0.
REQ-038 Halfword write, addr=0x...22, wdata=0x0000ABCD -> mem_be=0011, mem_wdata=0xABCDABCD, mem_we high for one cycle.
REQ-039 Word read at addr=0x...06 -> no mem_en, AE=1, MOC high the edge after acceptance, rdata unchanged.
REQ-040 MOV held high for 3 cycles after MOC -> MOC stays high, no second access; MOV low -> IDLE on the next edge.
REQ-041 Reset pulsed during WAIT of a write -> all outputs 0 immediately; the next request completes normally with correct latency.
